// File: rtl/slave_store.sv
// slave_store: AHB-Lite subordinate for the core's store path. It merges byte
// lanes into a word memory, with optional wait states and a two-cycle ERROR.
module slave_store #(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        hsel_i,
    input  logic [31:0] haddr_i,
    input  logic [1:0]  htrans_i,
    input  logic        hwrite_i,
    input  logic [2:0]  hsize_i,
    input  logic [31:0] hwdata_i,
    input  logic        hready_i,
    output logic        hreadyout_o,
    output logic        hresp_o,
    output logic [31:0] hrdata_o,
    output logic [3:0]  wr_strb_o,
    output logic [2:0]  state_o      // 0 IDLE, 1 DATA, 2 WAIT, 3 ERR1, 4 ERR2
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [2:0] WAIT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_DATA = 3'd1,
        S_WAIT = 3'd2,
        S_ERR1 = 3'd3,
        S_ERR2 = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [AW-1:0] idx_q;
    logic [1:0]    lo_q;
    logic [2:0]    size_q;
    logic          write_q;
    logic [31:0]   mem_q [DEPTH];

    logic          accept;
    logic          addr_err;
    logic          commit;
    logic [3:0]    strb;
    logic          unused_bits;

    // Handshake: an address phase is taken only on a cycle where the bus
    // (hready_i) and this slave (hreadyout_o) are both ready and the master
    // presents an active transfer; the data phase completes on the cycle
    // hreadyout_o is high.
    assign accept   = hsel_i & htrans_i[1] & hready_i & hreadyout_o;
    assign addr_err = (hsize_i >= 3'b011)
                    | ((hsize_i == 3'b001) & haddr_i[0])
                    | ((hsize_i == 3'b010) & (haddr_i[1:0] != 2'b00));

    assign unused_bits = ^{haddr_i[31:AW+2], htrans_i[0]};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE, S_DATA, S_ERR2: begin
                if (accept) begin
                    if (addr_err) begin
                        state_d = S_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_ERR1:  state_d = S_ERR2;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        hreadyout_o = 1'b1;
        hresp_o     = 1'b0;
        case (state_q)
            S_WAIT: hreadyout_o = 1'b0;
            S_ERR1: begin
                hreadyout_o = 1'b0;
                hresp_o     = 1'b1;
            end
            S_ERR2:  hresp_o = 1'b1;
            default: ;
        endcase
    end

    assign state_o = state_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idx_q   <= '0;
            lo_q    <= 2'b00;
            size_q  <= 3'b000;
            write_q <= 1'b0;
        end else if (accept) begin
            idx_q   <= haddr_i[AW+1:2];
            lo_q    <= haddr_i[1:0];
            size_q  <= hsize_i;
            write_q <= hwrite_i;
        end
    end

    // Illegal sizes never reach DATA, so the default lane set is a full word.
    always_comb begin
        strb = 4'b1111;
        case (size_q)
            3'b000:  strb = 4'b0001 << lo_q;
            3'b001:  strb = lo_q[1] ? 4'b1100 : 4'b0011;
            default: strb = 4'b1111;
        endcase
    end

    // A reset landing on the completing cycle drops the write.
    assign commit    = (state_q == S_DATA) & write_q & ~rst_i;
    assign wr_strb_o = commit ? strb : 4'b0000;
    assign hrdata_o  = ((state_q == S_DATA) && !write_q) ? mem_q[idx_q] : 32'd0;

    always_ff @(posedge clk_i) begin
        if (commit) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) begin
                    mem_q[idx_q][8*b +: 8] <= hwdata_i[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_slave_store.sv
// Bench for slave_store: three instances (0, 2 and 3 wait states) checked every
// cycle against a transaction-level model of the bus response and memory.
module tb_slave_store;
    localparam int NI    = 3;
    localparam int DEPTH = 256;
    localparam logic [37:0] IDLE_RSP = {1'b1, 1'b0, 4'b0000, 32'd0};

    logic        clk;
    logic        rst       [NI];
    logic        hsel      [NI];
    logic [31:0] haddr     [NI];
    logic [1:0]  htrans    [NI];
    logic        hwrite    [NI];
    logic [2:0]  hsize     [NI];
    logic [31:0] hwdata    [NI];
    logic        hready    [NI];
    logic        hreadyout [NI];
    logic        hresp     [NI];
    logic [31:0] hrdata    [NI];
    logic [3:0]  wr_strb   [NI];
    logic [2:0]  state     [NI];

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;
    bit cmp_en = 0;
    int next_free [NI];

    logic [31:0] mdl_mem [NI][DEPTH];
    logic [37:0] exp_at [int];
    logic [31:0] wd_at  [int];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        assign hready[g] = hreadyout[g];
        slave_store #(
            .DEPTH      (DEPTH),
            .WAIT_STATES((g == 0) ? 0 : (g == 1) ? 2 : 3)
        ) u_dut (
            .clk_i      (clk),
            .rst_i      (rst[g]),
            .hsel_i     (hsel[g]),
            .haddr_i    (haddr[g]),
            .htrans_i   (htrans[g]),
            .hwrite_i   (hwrite[g]),
            .hsize_i    (hsize[g]),
            .hwdata_i   (hwdata[g]),
            .hready_i   (hready[g]),
            .hreadyout_o(hreadyout[g]),
            .hresp_o    (hresp[g]),
            .hrdata_o   (hrdata[g]),
            .wr_strb_o  (wr_strb[g]),
            .state_o    (state[g])
        );
    end

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    // ---------------- model helpers ----------------
    function automatic int ws_of(input int d);
        return (d == 0) ? 0 : (d == 1) ? 2 : 3;
    endfunction

    function automatic logic [3:0] strb_of(input logic [2:0] size, input logic [1:0] lo);
        if (size == 3'b000) return 4'b0001 << lo;
        if (size == 3'b001) return lo[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic is_err(input logic [2:0] size, input logic [1:0] lo);
        return (size >= 3'b011) || (size == 3'b001 && lo[0]) || (size == 3'b010 && lo != 2'b00);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    // hwdata follows the data-phase schedule; unscheduled cycles carry noise.
    always @(posedge clk) begin
        #1;
        for (int d = 0; d < NI; d++) begin
            if (wd_at.exists(cyc * NI + d)) hwdata[d] = wd_at[cyc * NI + d];
            else hwdata[d] = $urandom;
        end
    end

    task automatic xfer(input int d, input logic [31:0] addr, input logic wr,
                        input logic [2:0] size, input logic [31:0] wdata);
        int n;
        int ws;
        int idx;
        logic [3:0] s;
        while (cyc < next_free[d]) step();
        n   = cyc;
        ws  = ws_of(d);
        idx = int'(addr[9:2]);
        hsel[d]   = 1'b1;
        htrans[d] = 2'b10;
        haddr[d]  = addr;
        hwrite[d] = wr;
        hsize[d]  = size;
        if (is_err(size, addr[1:0])) begin
            exp_at[(n + 1) * NI + d] = {1'b0, 1'b1, 4'b0000, 32'd0};
            exp_at[(n + 2) * NI + d] = {1'b1, 1'b1, 4'b0000, 32'd0};
            next_free[d] = n + 2;
        end else begin
            s = strb_of(size, addr[1:0]);
            for (int k = 1; k <= ws; k++) exp_at[(n + k) * NI + d] = 38'd0;
            for (int k = 1; k <= ws + 1; k++) wd_at[(n + k) * NI + d] = wdata;
            if (wr) begin
                for (int b = 0; b < 4; b++)
                    if (s[b]) mdl_mem[d][idx][8*b +: 8] = wdata[8*b +: 8];
                exp_at[(n + ws + 1) * NI + d] = {1'b1, 1'b0, s, 32'd0};
            end else begin
                exp_at[(n + ws + 1) * NI + d] = {1'b1, 1'b0, 4'b0000, mdl_mem[d][idx]};
            end
            next_free[d] = n + ws + 1;
        end
        step();
        hsel[d]   = 1'b0;
        htrans[d] = 2'b00;
    endtask

    task automatic idle_cycle(input int d, input logic sel, input logic [1:0] trans);
        while (cyc < next_free[d]) step();
        hsel[d]   = sel;
        htrans[d] = trans;
        haddr[d]  = $urandom;
        hwrite[d] = 1'b1;
        hsize[d]  = 3'b010;
        step();
        hsel[d]   = 1'b0;
        htrans[d] = 2'b00;
        next_free[d] = cyc;
    endtask

    // Write to 0x50 on the 3-wait instance with reset pulsed in its second wait cycle.
    task automatic reset_mid_wait();
        int n;
        while (cyc < next_free[2]) step();
        n = cyc;
        hsel[2]   = 1'b1;
        htrans[2] = 2'b10;
        haddr[2]  = 32'h50;
        hwrite[2] = 1'b1;
        hsize[2]  = 3'b010;
        exp_at[(n + 1) * NI + 2] = 38'd0;
        exp_at[(n + 2) * NI + 2] = 38'd0;
        for (int k = 1; k <= 4; k++) wd_at[(n + k) * NI + 2] = 32'h55555555;
        step();
        hsel[2]   = 1'b0;
        htrans[2] = 2'b00;
        step();
        rst[2] = 1'b1;
        step();
        rst[2] = 1'b0;
        next_free[2] = cyc;
        @(negedge clk);
        check("rst_mid_wait.state", {29'd0, state[2]}, 32'd0);
        check("rst_mid_wait.hreadyout", {31'd0, hreadyout[2]}, 32'd1);
        check("rst_mid_wait.hresp", {31'd0, hresp[2]}, 32'd0);
        step();
    endtask

    // ---------------- scoreboard / compare ----------------
    always @(negedge clk) begin
        if (cmp_en) begin
            for (int d = 0; d < NI; d++) begin
                logic [37:0] exp;
                logic [37:0] act;
                exp = exp_at.exists(cyc * NI + d) ? exp_at[cyc * NI + d] : IDLE_RSP;
                act = {hreadyout[d], hresp[d], wr_strb[d], hrdata[d]};
                n_tests++;
                if (act !== exp) begin
                    n_fail++;
                    $display("FAIL bus[%0d] cyc=%0d: got ready=%b resp=%b strb=%b rdata=%h expected ready=%b resp=%b strb=%b rdata=%h",
                             d, cyc, act[37], act[36], act[35:32], act[31:0],
                             exp[37], exp[36], exp[35:32], exp[31:0]);
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        for (int d = 0; d < NI; d++) begin
            rst[d] = 1'b1; hsel[d] = 1'b0; haddr[d] = 32'd0; htrans[d] = 2'b00;
            hwrite[d] = 1'b0; hsize[d] = 3'b000; next_free[d] = 0;
        end
        repeat (3) step();
        for (int d = 0; d < NI; d++) rst[d] = 1'b0;
        cmp_en = 1'b1;
        @(negedge clk);
        for (int d = 0; d < NI; d++) check("reset.state", {29'd0, state[d]}, 32'd0);
        step();

        check("strb.byte2", {28'd0, strb_of(3'b000, 2'b10)}, 32'h4);
        check("strb.half_hi", {28'd0, strb_of(3'b001, 2'b10)}, 32'hC);

        // word write then back-to-back read
        xfer(0, 32'h10, 1'b1, 3'b010, 32'hDEADBEEF);
        xfer(0, 32'h10, 1'b0, 3'b010, 32'h0);

        // byte lanes
        xfer(0, 32'h20, 1'b1, 3'b010, 32'h11223344);
        xfer(0, 32'h22, 1'b1, 3'b000, 32'h00AB0000);
        check("model.byte_merge", mdl_mem[0][8], 32'h11AB3344);
        xfer(0, 32'h20, 1'b0, 3'b010, 32'h0);
        xfer(0, 32'h21, 1'b1, 3'b000, 32'h0000CD00);
        xfer(0, 32'h23, 1'b1, 3'b000, 32'hEF000000);
        xfer(0, 32'h20, 0, 3'b010, 32'h0);
        check("model.byte_lanes", mdl_mem[0][8], 32'hEFABCD44);

        // halfwords
        xfer(0, 32'h30, 1'b1, 3'b010, 32'h11223344);
        xfer(0, 32'h32, 1'b1, 3'b001, 32'hCAFE0000);
        check("model.half_hi", mdl_mem[0][12], 32'hCAFE3344);
        xfer(0, 32'h30, 1'b0, 3'b010, 32'h0);
        xfer(0, 32'h30, 1'b1, 3'b001, 32'h0000BEEF);
        xfer(0, 32'h30, 1'b0, 3'b010, 32'h0);

        // address wrap modulo DEPTH words
        xfer(0, 32'h410, 1'b1, 3'b010, 32'h12345678);
        xfer(0, 32'h10, 1'b0, 3'b010, 32'h0);
        check("model.wrap", mdl_mem[0][4], 32'h12345678);

        // inactive transfers
        idle_cycle(0, 1'b1, 2'b01);
        idle_cycle(0, 1'b1, 2'b00);
        idle_cycle(0, 1'b0, 2'b10);

        // misaligned and illegal sizes, no wait states
        xfer(0, 32'h40, 1'b1, 3'b010, 32'h0BADF00D);
        xfer(0, 32'h41, 1'b1, 3'b001, 32'hFFFFFFFF);
        xfer(0, 32'h42, 1'b1, 3'b010, 32'hFFFFFFFF);
        xfer(0, 32'h44, 1'b1, 3'b011, 32'hFFFFFFFF);
        xfer(0, 32'h43, 1'b0, 3'b001, 32'h0);
        xfer(0, 32'h40, 1'b0, 3'b010, 32'h0);
        check("model.err_no_write", mdl_mem[0][16], 32'h0BADF00D);

        // two wait states: errors stay two cycles, writes back to back
        xfer(1, 32'h40, 1'b1, 3'b010, 32'h01020304);
        xfer(1, 32'h41, 1'b1, 3'b001, 32'hFFFFFFFF);
        xfer(1, 32'h42, 1'b1, 3'b010, 32'hFFFFFFFF);
        xfer(1, 32'h40, 1'b0, 3'b010, 32'h0);
        xfer(1, 32'h60, 1'b1, 3'b010, 32'hAAAA0001);
        xfer(1, 32'h64, 1'b1, 3'b010, 32'hAAAA0002);
        xfer(1, 32'h68, 1'b1, 3'b010, 32'hAAAA0003);
        xfer(1, 32'h66, 1'b1, 3'b000, 32'h00770000);
        xfer(1, 32'h60, 1'b0, 3'b010, 32'h0);
        xfer(1, 32'h64, 1'b0, 3'b010, 32'h0);
        xfer(1, 32'h68, 1'b0, 3'b010, 32'h0);
        check("model.ws2_byte", mdl_mem[1][25], 32'hAA770002);

        // three wait states: reset during the second wait cycle
        xfer(2, 32'h50, 1'b1, 3'b010, 32'hA5A5A5A5);
        reset_mid_wait();
        xfer(2, 32'h50, 1'b0, 3'b010, 32'h0);
        check("model.rst_no_commit", mdl_mem[2][20], 32'hA5A5A5A5);
        xfer(2, 32'h52, 1'b1, 3'b001, 32'h5A5A0000);
        xfer(2, 32'h50, 1'b0, 3'b010, 32'h0);

        for (int d = 0; d < NI; d++) while (cyc < next_free[d] + 2) step();
        repeat (2) step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/slave_store.md
# slave_store

AHB-Lite subordinate for the store direction of the core's memory path. It is the write-side counterpart of the load extractor. It captures the address phase, checks size/alignment, and derives byte-lane strobes from haddr[1:0]/hsize. In the data phase it merges hwdata lanes into a word-organised memory, with optional wait states and a two-cycle ERROR response for illegal transfers. Reads return the raw aligned word; sign/zero extension is done downstream by the load extractor.

## Interface
- DEPTH, 256: memory size in 32-bit words (power of two); word index = haddr[log2(DEPTH)+1:2].
- WAIT_STATES, 0: number of hreadyout-low cycles inserted in every OKAY data phase (0–7).
- clk  input  1  rising-edge clock. One clock domain.
- rst  input  1  reset, synchronous, active-high.
- hsel  input  1  slave select.
- haddr  input  32  byte address (address phase).
- htrans  input  2  transfer type; NONSEQ=10 and SEQ=11 are active, IDLE/BUSY are ignored.
- hwrite  input  1  1 = write, 0 = read.
- hsize  input  3  000 byte, 001 half, 010 word; 011 and above are illegal.
- hwdata  input  32  write data (data phase), already on AHB byte lanes.
- hready  input  1  bus-level ready; the address phase is sampled only when high.
- hreadyout  output  1  data-phase completion.
- hresp  output  1  0 OKAY, 1 ERROR.
- hrdata  output  32  read data.
- wr_strb  output  4  byte enables applied on the cycle a write commits; 0 otherwise.

## Operation
- Address-phase capture: when hsel & htrans[1] & hready, register the word index, addr[1:0], hsize, hwrite, and err.
- err = (hsize≥011) | (hsize==001 & haddr[0]) | (hsize==010 & haddr[1:0]!=0).
- Strobe rules:
  - Byte: 4'b0001 << addr[1:0].
  - Half: addr[1] ? 1100 : 0011.
  - Word: 1111.
- A write commits at the rising edge ending an OKAY data phase, i.e. the edge where hreadyout=1. Only lanes with a strobe bit set are updated; the other bytes are preserved. wr_strb equals the strobe during that cycle.
- Read: hrdata = mem[word index] during the completing cycle; 0 otherwise. No extension or shifting is applied.
- FSM states:
  - IDLE: no pending data phase.
    - Accepted transfer with err → ERR1.
    - Accepted transfer with WAIT_STATES>0 → WAIT, counter loaded with WAIT_STATES-1.
    - Otherwise → DATA.
  - DATA: completing cycle.
    - A new accepted transfer follows the same rules as IDLE.
    - No new transfer → IDLE.
  - WAIT: hreadyout=0; the counter decrements. At 0 → DATA.
  - ERR1: hreadyout=0, hresp=1 → ERR2.
  - ERR2: hreadyout=1, hresp=1. No memory write; wr_strb=0. The next transfer is accepted the same as in DATA.
- While hreadyout=0, hready is low on the bus and no new address phase is captured.
- Pipelining: the next address phase overlaps the current completing data phase.

## Timing
- Reset values: hreadyout=1, hresp=0, hrdata=0, wr_strb=0, FSM=IDLE, wait counter=0. Memory contents are not cleared.
- Reset asserted mid-transfer: at the next edge, go to IDLE and drop the pending transfer. A pending write does not commit.
- WAIT_STATES=0: each data phase is 1 cycle, giving back-to-back throughput of one transfer per cycle.
- WAIT_STATES=N: each data phase is N+1 cycles; hreadyout is low for exactly N cycles.
- ERROR transfer: always 2 cycles, independent of WAIT_STATES.
- Read-after-write to the same word, back-to-back: the read returns the merged new data, because the write commits at the edge before the read's completing cycle.
- Out-of-range address: the word index truncates, wrapping modulo DEPTH. No error is raised.
- htrans IDLE/BUSY, or hsel=0: the next cycle is IDLE with the OKAY zero-wait response (hreadyout=1, hresp=0).

## Test plan
- Word write then read, WAIT_STATES=0:
  - Write 0xDEADBEEF to 0x10, then read 0x10.
  - Required: wr_strb=1111 on the write; hrdata=0xDEADBEEF one cycle later; hreadyout stays 1 throughout.
- Byte lanes:
  - Word 0x11223344 at 0x20, then byte write to 0x22 with hwdata=0x00AB0000, then read 0x20.
  - Required: wr_strb=0100; hrdata=0x11AB3344.
- Halfword:
  - Word 0x11223344 at 0x30, then half write to 0x32 with hwdata=0xCAFE0000.
  - Required: wr_strb=1100; read returns 0xCAFE3344.
- Misaligned:
  - Half write to 0x41, then word write to 0x42.
  - Required for each: hresp=1 for 2 cycles with hreadyout 0 then 1; wr_strb=0; word 0x40 unchanged.
- Wait states, WAIT_STATES=2:
  - Back-to-back word writes.
  - Required: hreadyout pattern 0,0,1 per transfer; data commits only on the hreadyout=1 cycle.
- Reset mid-wait:
  - WAIT_STATES=3; assert rst during the second wait cycle of a write of 0x55555555 to 0x50.
  - Required: next cycle hreadyout=1, hresp=0, FSM=IDLE; read of 0x50 returns its prior value.
